// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX pipeline register with MEM/WB operand forwarding and
//            load-use hazard detection for the execute stage.
// Option   : define EX_OPERAND_STAGE_FWD_EN to build the forwarding muxes.
// Revision : 1.0
// ============================================================================
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            valid_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic            alu_src_d,
  input  logic [2:0]      alu_control_d,
  input  logic            reg_write_d,
  input  logic            mem_write_d,
  input  logic [1:0]      result_src_d,
  input  logic [4:0]      rd_m,
  input  logic            reg_write_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [4:0]      rd_w,
  input  logic            reg_write_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] src_a_e,
  output logic [XLEN-1:0] src_b_e,
  output logic [2:0]      alu_control_e,
  output logic [XLEN-1:0] write_data_e,
  output logic [4:0]      rd_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            valid_e,
  output logic [1:0]      result_src_e,
  output logic [XLEN-1:0] pc_e,
  output logic            lw_stall
);

  logic            r_valid;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic            r_alu_src;
  logic [2:0]      r_alu_control;
  logic            r_reg_write;
  logic            r_mem_write;
  logic [1:0]      r_result_src;

  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  // Flush outranks stall so a squashed instruction never lingers in E.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid       <= 1'b0;
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm         <= '0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_alu_src     <= 1'b0;
      r_alu_control <= '0;
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_result_src  <= '0;
    end else if (flush_e) begin
      r_valid       <= 1'b0;
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm         <= '0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_alu_src     <= 1'b0;
      r_alu_control <= '0;
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_result_src  <= '0;
    end else if (!stall_e) begin
      r_valid       <= valid_d;
      r_rd1         <= rd1_d;
      r_rd2         <= rd2_d;
      r_imm         <= imm_d;
      r_pc          <= pc_d;
      r_rs1         <= rs1_d;
      r_rs2         <= rs2_d;
      r_rd          <= rd_d;
      r_alu_src     <= alu_src_d;
      r_alu_control <= alu_control_d;
      r_reg_write   <= reg_write_d & valid_d;
      r_mem_write   <= mem_write_d & valid_d;
      r_result_src  <= result_src_d;
    end
  end

`ifdef EX_OPERAND_STAGE_FWD_EN
  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    w_fwd_a = 2'b00;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == r_rs1))
      w_fwd_a = 2'b10;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == r_rs1))
      w_fwd_a = 2'b01;
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == r_rs2))
      w_fwd_b = 2'b10;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == r_rs2))
      w_fwd_b = 2'b01;
  end
`else
  logic w_unused_fwd;

  assign w_fwd_a      = 2'b00;
  assign w_fwd_b      = 2'b00;
  assign w_unused_fwd = ^{rd_m, reg_write_m, rd_w, reg_write_w};
`endif

  always_comb begin
    w_rs1_val = r_rd1;
    case (w_fwd_a)
      2'b10:   w_rs1_val = alu_result_m;
      2'b01:   w_rs1_val = result_w;
      default: w_rs1_val = r_rd1;
    endcase
  end

  always_comb begin
    w_rs2_val = r_rd2;
    case (w_fwd_b)
      2'b10:   w_rs2_val = alu_result_m;
      2'b01:   w_rs2_val = result_w;
      default: w_rs2_val = r_rd2;
    endcase
  end

  assign src_a_e       = w_rs1_val;
  assign write_data_e  = w_rs2_val;
  assign src_b_e       = r_alu_src ? r_imm : w_rs2_val;

  assign alu_control_e = r_alu_control;
  assign rd_e          = r_rd;
  assign rs1_e         = r_rs1;
  assign rs2_e         = r_rs2;
  assign reg_write_e   = r_reg_write;
  assign mem_write_e   = r_mem_write;
  assign valid_e       = r_valid;
  assign result_src_e  = r_result_src;
  assign pc_e          = r_pc;

  // A load in E whose destination feeds the instruction in decode.
  assign lw_stall = r_valid && (r_result_src == 2'b01) && (r_rd != 5'd0) &&
                    ((r_rd == rs1_d) || (r_rd == rs2_d));

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Purpose  : Self-checking bench for ex_operand_stage against a queue-free
//            behavioural model of the E register and forwarding rules.
// Revision : 1.0
// ============================================================================
module tb_ex_operand_stage;

  localparam int XLEN = 32;
`ifdef EX_OPERAND_STAGE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_e, flush_e, valid_d;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d, pc_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic            alu_src_d;
  logic [2:0]      alu_control_d;
  logic            reg_write_d, mem_write_d;
  logic [1:0]      result_src_d;
  logic [4:0]      rd_m, rd_w;
  logic            reg_write_m, reg_write_w;
  logic [XLEN-1:0] alu_result_m, result_w;
  logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, pc_e;
  logic [2:0]      alu_control_e;
  logic [4:0]      rd_e, rs1_e, rs2_e;
  logic            reg_write_e, mem_write_e, valid_e, lw_stall;
  logic [1:0]      result_src_e;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model of the instruction currently sitting in E.
  logic            m_valid, m_rw, m_mw, m_asrc;
  logic [1:0]      m_rsrc;
  logic [2:0]      m_alu;
  logic [XLEN-1:0] m_rd1, m_rd2, m_imm, m_pc;
  logic [4:0]      m_rs1, m_rs2, m_rd;

  ex_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .alu_src_d(alu_src_d), .alu_control_d(alu_control_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .result_src_d(result_src_d), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .alu_result_m(alu_result_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .result_w(result_w), .src_a_e(src_a_e), .src_b_e(src_b_e),
    .alu_control_e(alu_control_e), .write_data_e(write_data_e),
    .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .valid_e(valid_e),
    .result_src_e(result_src_e), .pc_e(pc_e), .lw_stall(lw_stall)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mw = 0; m_asrc = 0; m_rsrc = 0; m_alu = 0;
    m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
  endtask

  // Value an operand register index should resolve to right now.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] regval);
    if (FWD_EN && reg_write_m && rd_m != 0 && rd_m == rs) return alu_result_m;
    if (FWD_EN && reg_write_w && rd_w != 0 && rd_w == rs) return result_w;
    return regval;
  endfunction

  function automatic logic exp_lw();
    return m_valid && m_rsrc == 2'd1 && m_rd != 0 && (m_rd == rs1_d || m_rd == rs2_d);
  endfunction

  // One rising edge; the model takes the same inputs the DUT sees at that edge.
  task automatic step();
    @(posedge clk);
    if (!rst) model_clear();
    else if (flush_e) model_clear();
    else if (!stall_e) begin
      m_valid = valid_d; m_rw = reg_write_d & valid_d; m_mw = mem_write_d & valid_d;
      m_asrc = alu_src_d; m_rsrc = result_src_d; m_alu = alu_control_d;
      m_rd1 = rd1_d; m_rd2 = rd2_d; m_imm = imm_d; m_pc = pc_d;
      m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
    end
    #1;
  endtask

  task automatic idle_inputs();
    stall_e = 0; flush_e = 0; valid_d = 0; rd1_d = 0; rd2_d = 0; imm_d = 0;
    pc_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0; alu_src_d = 0; alu_control_d = 0;
    reg_write_d = 0; mem_write_d = 0; result_src_d = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0; alu_result_m = 0; result_w = 0;
  endtask

  task automatic test_reset();
    logic [XLEN*3+31:0] got;
    idle_inputs();
    rst = 0;
    rd_m = 5'd5; reg_write_m = 1; alu_result_m = 32'hDEAD_BEEF;
    model_clear();
    #2;
    got = {src_a_e, src_b_e, write_data_e, alu_control_e, rd_e, rs1_e, rs2_e,
           reg_write_e, mem_write_e, valid_e, result_src_e, lw_stall, 5'd0};
    tests_run++;
    if (got !== '0 || pc_e !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got outputs=%h pc=%h, required all zero", got, pc_e);
    end
    @(negedge clk); rst = 1;
    idle_inputs();
    step();
  endtask

  task automatic test_capture();
    valid_d = 1; rd1_d = 5; rd2_d = 7; alu_src_d = 0; alu_control_d = 3'b000;
    rs1_d = 1; rs2_d = 2; rd_d = 9; reg_write_d = 1; pc_d = 32'h100;
    step();
    idle_inputs();
    #1;
    tests_run++;
    if (src_a_e !== 32'd5 || src_b_e !== 32'd7 || alu_control_e !== 3'b000) begin
      tests_failed++;
      $display("FAIL plain_capture: got a=%h b=%h alu=%b, required a=5 b=7 alu=000",
               src_a_e, src_b_e, alu_control_e);
    end
    tests_run++;
    if (valid_e !== 1'b1 || reg_write_e !== 1'b1 || pc_e !== 32'h100 || rd_e !== 5'd9) begin
      tests_failed++;
      $display("FAIL capture_ctrl: got v=%b rw=%b pc=%h rd=%0d, required v=1 rw=1 pc=100 rd=9",
               valid_e, reg_write_e, pc_e, rd_e);
    end
    // A non-valid slot must not leak write enables into E.
    valid_d = 0; reg_write_d = 1; mem_write_d = 1;
    step();
    tests_run++;
    if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || mem_write_e !== 1'b0) begin
      tests_failed++;
      $display("FAIL invalid_gating: got v=%b rw=%b mw=%b, required 0 0 0",
               valid_e, reg_write_e, mem_write_e);
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    valid_d = 1; rd1_d = 32'h1111; pc_d = 32'h44; rd_d = 6; reg_write_d = 1;
    alu_control_d = 3'b101; result_src_d = 2'b01; rs1_d = 7;
    step();
    rs1_d = 6;
    #2; rst = 0; #1;
    tests_run++;
    if (valid_e !== 0 || pc_e !== 0 || src_a_e !== 0 || alu_control_e !== 0 ||
        rd_e !== 0 || lw_stall !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset: got v=%b pc=%h a=%h alu=%b rd=%0d lw=%b, required all 0",
               valid_e, pc_e, src_a_e, alu_control_e, rd_e, lw_stall);
    end
    model_clear();
    @(negedge clk); rst = 1;
    idle_inputs();
    step();
  endtask

  task automatic test_forwarding();
    logic [XLEN-1:0] exp;
    valid_d = 1; rs1_d = 3; rd1_d = 32'hAAAA; rs2_d = 0; rd2_d = 32'h3;
    step();
    idle_inputs();
    rd_m = 3; alu_result_m = 32'h10; reg_write_m = 1;
    rd_w = 3; result_w = 32'h20; reg_write_w = 1;
    #1;
    exp = FWD_EN ? 32'h10 : 32'hAAAA;
    tests_run++;
    if (src_a_e !== exp) begin
      tests_failed++;
      $display("FAIL fwd_mem_priority: got %h, required %h", src_a_e, exp);
    end
    reg_write_m = 0; #1;
    exp = FWD_EN ? 32'h20 : 32'hAAAA;
    tests_run++;
    if (src_a_e !== exp) begin
      tests_failed++;
      $display("FAIL fwd_wb: got %h, required %h", src_a_e, exp);
    end
    reg_write_m = 1; rd_m = 0; rd_w = 0; #1;
    tests_run++;
    if (src_a_e !== 32'hAAAA) begin
      tests_failed++;
      $display("FAIL fwd_x0_none: got %h, required %h", src_a_e, 32'hAAAA);
    end
    idle_inputs();
  endtask

  task automatic test_imm_store();
    logic [XLEN-1:0] exp;
    valid_d = 1; alu_src_d = 1; imm_d = 32'hFFFF_FFFC; rs2_d = 6; rd2_d = 32'h1234;
    mem_write_d = 1;
    step();
    idle_inputs();
    rd_w = 6; reg_write_w = 1; result_w = 32'h55;
    #1;
    exp = FWD_EN ? 32'h55 : 32'h1234;
    tests_run++;
    if (src_b_e !== 32'hFFFF_FFFC || write_data_e !== exp || mem_write_e !== 1'b1) begin
      tests_failed++;
      $display("FAIL imm_store: got b=%h wd=%h mw=%b, required b=fffffffc wd=%h mw=1",
               src_b_e, write_data_e, mem_write_e, exp);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    valid_d = 1; result_src_d = 2'b01; rd_d = 4; reg_write_d = 1;
    step();
    idle_inputs();
    rs1_d = 1; rs2_d = 4; #1;
    tests_run++;
    if (lw_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_hit: got %b, required 1", lw_stall);
    end
    rs1_d = 4; rs2_d = 9; #1;
    tests_run++;
    if (lw_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_rs1: got %b, required 1", lw_stall);
    end
    valid_d = 1; result_src_d = 2'b01; rd_d = 0;
    step();
    rs1_d = 0; rs2_d = 0; #1;
    tests_run++;
    if (lw_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_x0: got %b, required 0", lw_stall);
    end
    valid_d = 0; result_src_d = 2'b01; rd_d = 4;
    step();
    rs1_d = 4; rs2_d = 4; #1;
    tests_run++;
    if (lw_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_invalid: got %b, required 0", lw_stall);
    end
    idle_inputs();
  endtask

  task automatic test_stall_flush();
    valid_d = 1; reg_write_d = 1; pc_d = 32'h200; rd_d = 8;
    step();
    stall_e = 1; flush_e = 1; valid_d = 1; pc_d = 32'h300;
    step();
    tests_run++;
    if (valid_e !== 1'b0 || reg_write_e !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_over_stall: got v=%b rw=%b, required 0 0", valid_e, reg_write_e);
    end
    idle_inputs();
    valid_d = 1; reg_write_d = 1; pc_d = 32'h400; rd_d = 11; rd1_d = 32'hCAFE;
    alu_control_d = 3'b110; rs1_d = 12;
    step();
    for (int i = 0; i < 3; i++) begin
      stall_e = 1; valid_d = i[0]; pc_d = $urandom; rd_d = 5'($urandom);
      rd1_d = $urandom; alu_control_d = 3'($urandom); rs1_d = 5'($urandom);
      step();
      tests_run++;
      if (pc_e !== 32'h400 || rd_e !== 5'd11 || src_a_e !== 32'hCAFE ||
          alu_control_e !== 3'b110 || valid_e !== 1'b1 || rs1_e !== 5'd12) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got pc=%h rd=%0d a=%h alu=%b v=%b rs1=%0d, required pc=400 rd=11 a=cafe alu=110 v=1 rs1=12",
                 i, pc_e, rd_e, src_a_e, alu_control_e, valid_e, rs1_e);
      end
    end
    idle_inputs();
  endtask

  // Random traffic with small index space so matches and hazards are frequent.
  task automatic test_random();
    logic [XLEN-1:0] ea, eb, ew;
    logic [XLEN+24:0] exp_ctrl, got_ctrl;
    for (int n = 0; n < 300; n++) begin
      stall_e = ($urandom_range(0, 4) == 0); flush_e = ($urandom_range(0, 7) == 0);
      valid_d = $urandom; rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom;
      pc_d = $urandom; rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rd_d = 5'($urandom_range(0, 3)); alu_src_d = $urandom; alu_control_d = 3'($urandom);
      reg_write_d = $urandom; mem_write_d = $urandom; result_src_d = 2'($urandom_range(0, 2));
      step();
      rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
      reg_write_m = $urandom; reg_write_w = $urandom;
      alu_result_m = $urandom; result_w = $urandom;
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      #1;
      ea = fwd(m_rs1, m_rd1);
      ew = fwd(m_rs2, m_rd2);
      eb = m_asrc ? m_imm : ew;
      tests_run++;
      if (src_a_e !== ea || src_b_e !== eb || write_data_e !== ew) begin
        tests_failed++;
        $display("FAIL rand_operands[%0d]: got a=%h b=%h wd=%h, required a=%h b=%h wd=%h",
                 n, src_a_e, src_b_e, write_data_e, ea, eb, ew);
      end
      exp_ctrl = {m_pc, m_alu, m_rd, m_rs1, m_rs2, m_rw, m_mw, m_valid, m_rsrc, exp_lw()};
      got_ctrl = {pc_e, alu_control_e, rd_e, rs1_e, rs2_e, reg_write_e, mem_write_e,
                  valid_e, result_src_e, lw_stall};
      tests_run++;
      if (got_ctrl !== exp_ctrl) begin
        tests_failed++;
        $display("FAIL rand_control[%0d]: got %h, required %h", n, got_ctrl, exp_ctrl);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_mid_reset();
    test_forwarding();
    test_imm_store();
    test_load_use();
    test_stall_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-forwarding front end for the execute stage. It captures decoded instruction fields from decode, then resolves RAW hazards by forwarding from the MEM and WB stages. It drives the ALU's `A`, `B` and `alu_control` inputs and passes control bits downstream to the EX/MEM register. It also flags load-use hazards back to the hazard/stall logic.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports (reset is asynchronous, active-low; one clock):
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `stall_e`  in  1  hold E register contents.
- `flush_e`  in  1  load a bubble into E.
- `valid_d`  in  1  decode slot holds a real instruction.
- `rd1_d`, `rd2_d`  in  XLEN  register-file read data.
- `imm_d`  in  XLEN  immediate, already sign-extended.
- `pc_d`  in  XLEN  instruction PC.
- `rs1_d`, `rs2_d`, `rd_d`  in  5  register indices.
- `alu_src_d`  in  1  1 selects `imm` for ALU B.
- `alu_control_d`  in  3  ALU opcode, passed through.
- `reg_write_d`, `mem_write_d`  in  1  write enables.
- `result_src_d`  in  2  00 ALU, 01 load, 10 PC+4.
- `rd_m`  in  5  MEM-stage destination register.
- `reg_write_m`  in  1  MEM-stage write enable.
- `alu_result_m`  in  XLEN  MEM-stage ALU result.
- `rd_w`  in  5  WB-stage destination register.
- `reg_write_w`  in  1  WB-stage write enable.
- `result_w`  in  XLEN  WB-stage result.
- `src_a_e`, `src_b_e`  out  XLEN  ALU operands.
- `alu_control_e`  out  3  ALU opcode.
- `write_data_e`  out  XLEN  forwarded rs2 value, used as store data.
- `rd_e`, `rs1_e`, `rs2_e`  out  5  registered indices.
- `reg_write_e`, `mem_write_e`, `valid_e`  out  1  registered control.
- `result_src_e`  out  2  registered result select.
- `pc_e`  out  XLEN  registered PC.
- `lw_stall`  out  1  load-use hazard detected (combinational).

## Operation
- **E register update**, at each rising `clk` with `rst`=1:
  - `flush_e`=1: load a bubble. `valid_e`, `reg_write_e`, `mem_write_e` and `result_src_e` become 0; data fields are don't-care, and the implementation zeroes them.
  - else `stall_e`=1: hold all fields.
  - else: capture all `_d` inputs. `valid_e` is set from `valid_d`; `reg_write_e` and `mem_write_e` are ANDed with `valid_d`.
  - Flush has priority over stall.
- **Forwarding selection** is combinational from E-register contents. It is evaluated independently for rs1 (fwd_a) and rs2 (fwd_b):
  - `10`: MEM match. `reg_write_m`=1, `rd_m`≠0, `rd_m`==`rs*_e`.
  - else `01`: WB match. `reg_write_w`=1, `rd_w`≠0, `rd_w`==`rs*_e`.
  - else `00`: registered read data.
  - MEM has priority over WB. x0 is never forwarded.
- **Operand outputs:**
  - `src_a_e` = forwarded rs1.
  - `write_data_e` = forwarded rs2.
  - `src_b_e` = `imm_e` if `alu_src_e`, else forwarded rs2.
- **Load-use detection:** `lw_stall` = `valid_e` & (`result_src_e`==01) & `rd_e`≠0 & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
- No arithmetic is performed in this block. All data paths are XLEN wide with no truncation.

## Timing
- Reset value of every registered output is 0 (`valid_e`=0, `alu_control_e`=000, `pc_e`=0, ...).
- During reset, operand outputs resolve from zeroed state, so `src_a_e`=`src_b_e`=0. Exception: a WB/MEM match on a zero index cannot occur, because x0 is never forwarded.
- Latency: decode inputs appear on the E outputs 1 cycle after capture. Forward paths have zero cycles of latency (same-cycle combinational).
- `rst` asserted mid-operation clears the register immediately (async). Deassertion takes effect at the next edge.
- A held instruction (`stall_e`) re-evaluates forwarding every cycle, so newly arriving MEM/WB results are picked up.

## Configuration
- Macro: `EX_OPERAND_STAGE_FWD_EN`.
- Defined: forwarding muxes are present as described above.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - `src_a_e` = `rd1_e`, `write_data_e` = `rd2_e`.
  - `lw_stall` is unchanged.
  - Hazards must then be covered by stalls from the external hazard unit.

## Test plan
- **Reset:** assert `rst`=0 mid-stream → all registered outputs 0 within the same cycle; `lw_stall`=0.
- **Plain capture:** `rd1_d`=5, `rd2_d`=7, `alu_src_d`=0, `alu_control_d`=000, `valid_d`=1 → next cycle `src_a_e`=5, `src_b_e`=7, `alu_control_e`=000.
- **Forwarding priority:**
  - Setup: `rs1_e`=3; `rd_m`=3 with `alu_result_m`=0x10; `rd_w`=3 with `result_w`=0x20; both write enables 1.
  - Expected: `src_a_e`=0x10.
  - Then drop `reg_write_m` → `src_a_e`=0x20.
  - Then set `rd_m`=`rd_w`=0 → registered value.
- **Immediate and store data:** `alu_src_e`=1, `imm`=0xFFFFFFFC, rs2 forwarded from WB as 0x55 → `src_b_e`=0xFFFFFFFC, `write_data_e`=0x55.
- **Load-use:** E holds a load with `rd_e`=4 and `valid_e`=1; set `rs2_d`=4 → `lw_stall`=1. Set `rd_e`=0 or `valid_e`=0 → `lw_stall`=0.
- **Stall/flush:** assert `stall_e` and `flush_e` together → bubble (`valid_e`=0, `reg_write_e`=0). Assert `stall_e` alone for 3 cycles → E fields unchanged while `_d` inputs toggle.
